// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline (mem wait, branch flush, load-use).
// Optional MEM_WAIT timeout fault is compiled in with macro PIPE_CTRL_TIMEOUT_EN.
`default_nettype none

module pipeline_hazard_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [4:0] id_rs1_addr_i,
    input  logic [4:0] id_rs2_addr_i,
    input  logic       id_rs1_used_i,
    input  logic       id_rs2_used_i,
    input  logic [4:0] ex_reg_wr_addr_i,
    input  logic       ex_mem_rd_i,
    input  logic       branch_taken_i,
    input  logic       dmem_req_i,
    input  logic       dmem_ack_i,
    output logic       pc_en_o,
    output logic       if_id_en_o,
    output logic       if_id_flush_o,
    output logic       id_ex_en_o,
    output logic       id_ex_flush_o,
    output logic       ex_mem_en_o,
    output logic       mem_wb_flush_o,
    output logic [1:0] state_o,
    output logic       timeout_err_o
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    state_t state, state_next;
    logic   load_use;

    assign load_use = ex_mem_rd_i && (ex_reg_wr_addr_i != 5'd0) &&
                      ((id_rs1_used_i && (id_rs1_addr_i == ex_reg_wr_addr_i)) ||
                       (id_rs2_used_i && (id_rs2_addr_i == ex_reg_wr_addr_i)));

`ifdef PIPE_CTRL_TIMEOUT_EN
    logic [7:0] wait_cnt, wait_cnt_next;
    logic       timeout_err;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= RUN;
            wait_cnt    <= 8'd0;
            timeout_err <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (state_next == FAULT)
                timeout_err <= 1'b1;
        end
    end

    assign timeout_err_o = timeout_err;
`else
    logic [7:0] unused_timeout_limit;
    assign unused_timeout_limit = TIMEOUT_LIMIT;

    always_ff @(posedge clk) begin
        if (!reset_n)
            state <= RUN;
        else
            state <= state_next;
    end

    assign timeout_err_o = 1'b0;
`endif

    always_comb begin
        state_next     = state;
        pc_en_o        = 1'b1;
        if_id_en_o     = 1'b1;
        if_id_flush_o  = 1'b0;
        id_ex_en_o     = 1'b1;
        id_ex_flush_o  = 1'b0;
        ex_mem_en_o    = 1'b1;
        mem_wb_flush_o = 1'b0;
        state_o        = state;
`ifdef PIPE_CTRL_TIMEOUT_EN
        wait_cnt_next  = wait_cnt;
`endif

        case (state)
`ifdef PIPE_CTRL_TIMEOUT_EN
            FAULT: begin
                pc_en_o        = 1'b0;
                if_id_en_o     = 1'b0;
                id_ex_en_o     = 1'b0;
                ex_mem_en_o    = 1'b0;
                mem_wb_flush_o = 1'b1;
            end
`endif
            RUN, MEM_WAIT: begin
                // An outstanding access freezes everything upstream and bubbles WB.
                if ((state == MEM_WAIT) ? !dmem_ack_i : (dmem_req_i && !dmem_ack_i)) begin
                    pc_en_o        = 1'b0;
                    if_id_en_o     = 1'b0;
                    id_ex_en_o     = 1'b0;
                    ex_mem_en_o    = 1'b0;
                    mem_wb_flush_o = 1'b1;
                    state_next     = MEM_WAIT;
`ifdef PIPE_CTRL_TIMEOUT_EN
                    if (state == RUN) begin
                        wait_cnt_next = 8'd0;
                    end else begin
                        if (wait_cnt != 8'hFF)
                            wait_cnt_next = wait_cnt + 8'd1;
                        if (wait_cnt_next >= TIMEOUT_LIMIT)
                            state_next = FAULT;
                    end
`endif
                end else begin
                    state_next = RUN;
                    if (branch_taken_i) begin
                        if_id_flush_o = 1'b1;
                        id_ex_flush_o = 1'b1;
                    end else if (load_use) begin
                        pc_en_o       = 1'b0;
                        if_id_en_o    = 1'b0;
                        id_ex_flush_o = 1'b1;
                    end
                end
            end
            default: state_next = RUN;
        endcase

        // Reset cycles present a fully quiescent interface.
        if (!reset_n) begin
            pc_en_o        = 1'b0;
            if_id_en_o     = 1'b0;
            if_id_flush_o  = 1'b0;
            id_ex_en_o     = 1'b0;
            id_ex_flush_o  = 1'b0;
            ex_mem_en_o    = 1'b0;
            mem_wb_flush_o = 1'b0;
            state_o        = 2'd0;
        end
    end

endmodule

`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage pipeline. It drives per-register enable and flush strobes into the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and the PC enable. It resolves three conditions:
- data-memory wait states, through a req/ack handshake;
- taken-branch flushes;
- load-use hazards.

It sits beside the datapath in the core top level and owns no datapath storage.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: MEM_WAIT cycles before a timeout fault. Only used when the timeout is compiled in; range 1..255.

Ports (name, direction, width, meaning):
- clk  in  1  core clock; all state updates on the rising edge
- reset_n  in  1  reset, synchronous and active-low
- id_rs1_addr_i  in  5  rs1 of the instruction in ID
- id_rs2_addr_i  in  5  rs2 of the instruction in ID
- id_rs1_used_i  in  1  the ID instruction reads rs1
- id_rs2_used_i  in  1  the ID instruction reads rs2
- ex_reg_wr_addr_i  in  5  destination register of the instruction in EX
- ex_mem_rd_i  in  1  the instruction in EX is a load
- branch_taken_i  in  1  branch or jump resolved taken in EX
- dmem_req_i  in  1  MEM stage issues a data-memory access this cycle
- dmem_ack_i  in  1  data memory completes the access this cycle
- pc_en_o  out  1  PC register load enable
- if_id_en_o  out  1  IF/ID load enable
- if_id_flush_o  out  1  IF/ID loads a bubble (NOP, reg_wr_sig cleared)
- id_ex_en_o  out  1  ID/EX load enable
- id_ex_flush_o  out  1  ID/EX loads a bubble
- ex_mem_en_o  out  1  EX/MEM load enable
- mem_wb_flush_o  out  1  MEM/WB loads a bubble; reg_wr_sig_o becomes 0 next cycle
- state_o  out  2  FSM state: 0=RUN, 1=MEM_WAIT, 2=FAULT
- timeout_err_o  out  1  sticky timeout fault flag

## Operation
- FSM states are RUN, MEM_WAIT and FAULT. FAULT exists only with the macro.
- Outputs are Mealy: combinational from state and the current-cycle inputs.
- Flush has priority over enable in the pipeline registers. A register with flush=1 loads a bubble regardless of its enable.
- Priority when conditions coincide: FAULT > memory wait > branch flush > load-use.
- **Memory wait** (RUN with dmem_req_i=1 and dmem_ack_i=0): go to MEM_WAIT.
  - pc_en, if_id_en, id_ex_en and ex_mem_en are all 0.
  - mem_wb_flush=1.
  - Branch and load-use are not evaluated.
- **MEM_WAIT**: same outputs as the memory-wait cycle while dmem_ack_i=0.
  - On the dmem_ack_i=1 cycle, go to RUN.
  - In that cycle the outputs are evaluated exactly as in RUN with the wait condition false.
- **Branch taken**:
  - pc_en=1, if_id_flush=1, id_ex_flush=1.
  - All other enables 1, no other flushes.
- **Load-use** is true when all of the following hold:
  - ex_mem_rd_i=1;
  - ex_reg_wr_addr_i≠0;
  - (id_rs1_used_i and rs1 matches) or (id_rs2_used_i and rs2 matches).

  Response: pc_en=0, if_id_en=0, id_ex_flush=1; ex_mem_en=1. Exactly one bubble per hazard, since the load has left EX on the next cycle.
- **Nominal** (no condition active): all enables 1, all flushes 0.
- A same-cycle request and acknowledge (dmem_req_i=dmem_ack_i=1) in RUN causes no stall.
- dmem_ack_i without dmem_req_i in RUN is ignored.

## Timing
- While reset_n=0 at a rising edge:
  - next state is RUN, timeout counter 0, timeout_err_o 0.
  - During reset cycles, all enables are 0 and all flushes 0.
  - state_o reads 0.
- Reset asserted mid-wait returns the block to RUN on that edge, whatever dmem_ack_i is.
- Wait length is 1 stall cycle per cycle of dmem_ack_i low after the request. An ack on the request cycle gives 0 stall cycles.
- Stall and flush responses take effect on the same cycle: zero latency, combinational.
- The 8-bit timeout counter clears on entry to MEM_WAIT and increments each MEM_WAIT cycle without ack. It saturates and does not wrap.

## Configuration
- Macro: PIPE_CTRL_TIMEOUT_EN.
- **Defined**:
  - When the MEM_WAIT counter reaches TIMEOUT_CYCLES with no ack, go to FAULT.
  - In FAULT, every enable is 0, every flush is 0 except mem_wb_flush=1, timeout_err_o=1 and state_o=2.
  - FAULT is left only by reset.
- **Undefined**:
  - No counter and no FAULT state.
  - MEM_WAIT waits indefinitely.
  - timeout_err_o is tied to 0.

## Test plan
- Reset held 2 cycles, then released with no hazards -> state_o=0, all enables 1, all flushes 0 from the first cycle after release.
- ex_mem_rd_i=1, ex_reg_wr_addr_i=5, id_rs2_addr_i=5, id_rs2_used_i=1 -> one cycle of pc_en=0, if_id_en=0, id_ex_flush=1; back to nominal once ex_mem_rd_i drops. Repeating with ex_reg_wr_addr_i=0 -> no stall.
- dmem_req_i=1 with ack after 3 cycles -> 3 cycles of state_o=1 with the upstream enables 0 and mem_wb_flush=1, then RUN. Also req and ack in the same cycle -> 0 stall cycles.
- branch_taken_i=1 together with a load-use match -> if_id_flush=1, id_ex_flush=1, pc_en=1 (branch wins). Branch_taken during MEM_WAIT -> flush only on the ack cycle.
- With PIPE_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=4, a request never acked -> state_o=2 and timeout_err_o=1 after 4 wait cycles. Applying reset_n=0 for 1 cycle -> state_o=0, timeout_err_o=0.
